// File: rtl/rx_os_assembler.sv
`default_nettype none
// ============================================================================
// Module   : rx_os_assembler
// Purpose  : Collects per-lane PIPE receive symbols into 16-symbol ordered
//            sets, deskews completion across active lanes and presents the
//            aligned 2048-bit bus with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module rx_os_assembler #(
  parameter int PIPEWIDTH  = 8,
  parameter int SKEW_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    Gen,
  input  logic [4:0]                    numberOfDetectedLanes,
  input  logic [16*PIPEWIDTH-1:0]       rxData,
  input  logic [16*(PIPEWIDTH/8)-1:0]   rxDataK,
  input  logic [15:0]                   rxStartBlock,
  input  logic [31:0]                   rxSyncHeader,
  input  logic [15:0]                   rxDataValid,
  input  logic                          rxElectricalIdle,
  output logic [2047:0]                 orderedSets,
  output logic                          validOrderedSets,
  output logic                          skewError
);

  localparam int               c_SPC  = PIPEWIDTH / 8;
  localparam int               c_TW   = (SKEW_LIMIT < 2) ? 1 : $clog2(SKEW_LIMIT);
  localparam logic [c_TW-1:0]  c_TMAX = c_TW'(SKEW_LIMIT - 1);
  localparam logic [4:0]       c_STEP = 5'(c_SPC);
  localparam logic [4:0]       c_FULL = 5'd16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } laneState_t;

  logic [15:0]     w_active;
  logic [15:0]     w_done;
  logic [15:0]     w_doneNext;
  logic [2047:0]   w_osBus;

  logic [2:0]      r_prevGen;
  logic [4:0]      r_prevLanes;
  logic [c_TW-1:0] r_skewTimer;

  logic w_is8b10b;
  logic w_cfgChange;
  logic w_flush;
  logic w_anyDone;
  logic w_allDone;
  logic w_allDoneNext;
  logic w_release;
  logic w_timeout;
  logic w_abort;
  logic w_unusedK;

  // Only the slot-0 K flag of each lane can signal a COM; the rest are sunk.
  assign w_unusedK = ^rxDataK;

  assign w_is8b10b   = (Gen == 3'd1) || (Gen == 3'd2);
  assign w_cfgChange = (Gen != r_prevGen) || (numberOfDetectedLanes != r_prevLanes);
  assign w_flush     = rxElectricalIdle || w_cfgChange;

  assign w_anyDone     = |(w_done & w_active);
  assign w_allDone     = (numberOfDetectedLanes != 5'd0) && (&(w_done | ~w_active));
  assign w_allDoneNext = (numberOfDetectedLanes != 5'd0) && (&(w_doneNext | ~w_active));

  // Release beats a timeout: a timeout is only declared when the lagging
  // lanes will not all complete on this very edge.
  assign w_release = !w_flush && w_allDone;
  assign w_timeout = !w_flush && !w_allDone && w_anyDone &&
                     (r_skewTimer == c_TMAX) && !w_allDoneNext;
  assign w_abort   = w_flush || w_release || w_timeout;

  for (genvar i = 0; i < 16; i++) begin : g_lane
    laneState_t           r_state;
    laneState_t           w_stateNext;
    logic [127:0]         r_buf;
    logic [127:0]         w_bufNext;
    logic [4:0]           r_count;
    logic [4:0]           w_countNext;
    logic [PIPEWIDTH-1:0] w_laneData;
    logic [127:0]         w_beatWide;
    logic [127:0]         w_beatMask;
    logic [6:0]           w_shift;
    logic                 w_start;

    assign w_laneData = rxData[i*PIPEWIDTH +: PIPEWIDTH];
    assign w_beatWide = {{(128-PIPEWIDTH){1'b0}}, w_laneData};
    assign w_beatMask = {{(128-PIPEWIDTH){1'b0}}, {PIPEWIDTH{1'b1}}};
    assign w_shift    = {r_count[3:0], 3'b000};
    assign w_active[i] = (numberOfDetectedLanes > 5'(i));

    // Start is only ever looked for in symbol slot 0 of a beat.
    assign w_start = w_is8b10b
                   ? ((w_laneData[7:0] == 8'hBC) && rxDataK[i*c_SPC])
                   : (rxStartBlock[i] && (rxSyncHeader[2*i +: 2] == 2'b01));

    assign w_done[i]     = (r_state == DONE);
    assign w_doneNext[i] = (w_stateNext == DONE);
    assign w_osBus[i*128 +: 128] = w_active[i] ? r_buf : 128'h0;

    // Lane next-state: start/restart, append beats, detect a full set.
    always_comb begin
      w_stateNext = r_state;
      w_bufNext   = r_buf;
      w_countNext = r_count;
      case (r_state)
        IDLE: begin
          if (rxDataValid[i] && w_start) begin
            w_stateNext = COLLECT;
            w_bufNext   = w_beatWide;
            w_countNext = c_STEP;
          end
        end
        COLLECT: begin
          if (rxDataValid[i]) begin
            if (w_start) begin
              w_bufNext   = w_beatWide;
              w_countNext = c_STEP;
            end else begin
              w_bufNext   = (r_buf & ~(w_beatMask << w_shift)) | (w_beatWide << w_shift);
              w_countNext = r_count + c_STEP;
              if ((r_count + c_STEP) == c_FULL) begin
                w_stateNext = DONE;
              end
            end
          end
        end
        DONE: begin
          w_stateNext = DONE;
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
      if (!w_active[i]) begin
        w_stateNext = IDLE;
        w_countNext = 5'd0;
      end
    end

    // Lane state register; any global abort or release returns the lane to IDLE.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= IDLE;
        r_buf   <= 128'h0;
        r_count <= 5'd0;
      end else if (w_abort) begin
        r_state <= IDLE;
        r_buf   <= 128'h0;
        r_count <= 5'd0;
      end else begin
        r_state <= w_stateNext;
        r_buf   <= w_bufNext;
        r_count <= w_countNext;
      end
    end
  end

  // Remember the rate and lane count so a change aborts in-flight collection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prevGen   <= 3'd0;
      r_prevLanes <= 5'd0;
    end else begin
      r_prevGen   <= Gen;
      r_prevLanes <= numberOfDetectedLanes;
    end
  end

  // Skew timer runs only while the active lanes are partially complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skewTimer <= '0;
    end else if (w_abort || !w_anyDone) begin
      r_skewTimer <= '0;
    end else begin
      r_skewTimer <= r_skewTimer + c_TW'(1);
    end
  end

  // Output register: bus captured on release only, strobes last one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      orderedSets      <= '0;
      validOrderedSets <= 1'b0;
      skewError        <= 1'b0;
    end else begin
      validOrderedSets <= w_release;
      skewError        <= w_timeout;
      if (w_release) begin
        orderedSets <= w_osBus;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_os_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_os_assembler
// Purpose  : Self-checking bench for rx_os_assembler (8-bit Gen1 and 32-bit
//            Gen3 instances) against a behavioural ordered-set model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_os_assembler;

  localparam int SKEW = 8;
  localparam logic [127:0] L0_TS1 = 128'h0F0E0D0C_0B0A0908_07060504_03F7F7BC;
  localparam logic [127:0] L1_TS1 = 128'h1F1E1D1C_1B1A1918_17161514_13F7F7BC;
  localparam logic [127:0] L0_OS3 = 128'h0F0E0D0C_0B0A0908_07060504_0302011E;
  localparam logic [127:0] L7_OS3 = 128'h7F7E7D7C_7B7A7978_77767574_7372711E;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]    gen   [2];
  logic [4:0]    nl    [2];
  logic [15:0]   sb    [2];
  logic [15:0]   dv    [2];
  logic [31:0]   sh    [2];
  logic          eidle [2];
  logic [127:0]  rxD8;
  logic [15:0]   rxK8;
  logic [511:0]  rxD32;
  logic [63:0]   rxK32;
  logic [2047:0] os8, os32;
  logic          v8, v32, se8, se32;

  rx_os_assembler #(.PIPEWIDTH(8), .SKEW_LIMIT(SKEW)) dut8 (
    .clk(clk), .reset(reset), .Gen(gen[0]), .numberOfDetectedLanes(nl[0]),
    .rxData(rxD8), .rxDataK(rxK8), .rxStartBlock(sb[0]), .rxSyncHeader(sh[0]),
    .rxDataValid(dv[0]), .rxElectricalIdle(eidle[0]),
    .orderedSets(os8), .validOrderedSets(v8), .skewError(se8)
  );

  rx_os_assembler #(.PIPEWIDTH(32), .SKEW_LIMIT(SKEW)) dut32 (
    .clk(clk), .reset(reset), .Gen(gen[1]), .numberOfDetectedLanes(nl[1]),
    .rxData(rxD32), .rxDataK(rxK32), .rxStartBlock(sb[1]), .rxSyncHeader(sh[1]),
    .rxDataValid(dv[1]), .rxElectricalIdle(eidle[1]),
    .orderedSets(os32), .validOrderedSets(v32), .skewError(se32)
  );

  // ---------------- behavioural model ----------------
  logic [127:0]  mBuf [2][16];
  int            mCnt [2][16];
  int            mTimer [2];
  logic [2:0]    mPrevGen [2];
  logic [4:0]    mPrevN [2];
  logic [2047:0] eOS [2];
  logic          eValid [2], eSkew [2];

  int cyc = 0;
  int nChecks = 0, nPass = 0;
  int validCount [2] = '{0, 0};
  int skewCount  [2] = '{0, 0};
  int lastValidCyc [2] = '{-1, -1};
  int lastSkewCyc  [2] = '{-1, -1};

  function automatic logic [7:0] symAt(int k, int i, int s);
    if (k == 0) return rxD8[i*8 +: 8];
    return rxD32[i*32 + s*8 +: 8];
  endfunction

  function automatic logic isStart(int k, int i);
    if (gen[k] == 3'd1 || gen[k] == 3'd2)
      return (symAt(k, i, 0) == 8'hBC) && ((k == 0) ? rxK8[i] : rxK32[i*4]);
    return sb[k][i] && (sh[k][2*i +: 2] == 2'b01);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        mBuf[k][i] = '0;
        mCnt[k][i] = 0;
      end
      mTimer[k] = 0; mPrevGen[k] = '0; mPrevN[k] = '0;
      eOS[k] = '0; eValid[k] = 1'b0; eSkew[k] = 1'b0;
    end
  endtask

  task automatic modelStep(input int k);
    int  spc, n;
    bit  anyDone, allDone, allDoneNext;
    spc = (k == 0) ? 1 : 4;
    n   = int'(nl[k]);
    eValid[k] = 1'b0;
    eSkew[k]  = 1'b0;
    anyDone = 1'b0;
    allDone = (n != 0);
    for (int i = 0; i < 16; i++) begin
      if (i < n) begin
        if (mCnt[k][i] == 16) anyDone = 1'b1;
        else allDone = 1'b0;
      end
    end
    if (eidle[k] || gen[k] != mPrevGen[k] || nl[k] != mPrevN[k]) begin
      for (int i = 0; i < 16; i++) mCnt[k][i] = 0;
      mTimer[k] = 0;
    end else if (allDone) begin
      eOS[k] = '0;
      for (int i = 0; i < n && i < 16; i++) eOS[k][i*128 +: 128] = mBuf[k][i];
      eValid[k] = 1'b1;
      for (int i = 0; i < 16; i++) mCnt[k][i] = 0;
      mTimer[k] = 0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (i >= n) mCnt[k][i] = 0;
        else if (mCnt[k][i] != 16 && dv[k][i]) begin
          if (isStart(k, i)) begin
            mBuf[k][i] = '0;
            for (int s = 0; s < spc; s++) mBuf[k][i][s*8 +: 8] = symAt(k, i, s);
            mCnt[k][i] = spc;
          end else if (mCnt[k][i] > 0) begin
            for (int s = 0; s < spc; s++) mBuf[k][i][(mCnt[k][i]+s)*8 +: 8] = symAt(k, i, s);
            mCnt[k][i] += spc;
          end
        end
      end
      allDoneNext = (n != 0);
      for (int i = 0; i < n && i < 16; i++) if (mCnt[k][i] != 16) allDoneNext = 1'b0;
      if (anyDone) begin
        mTimer[k]++;
        if (mTimer[k] >= SKEW && !allDoneNext) begin
          for (int i = 0; i < 16; i++) begin
            mCnt[k][i] = 0;
            mBuf[k][i] = '0;
          end
          mTimer[k] = 0;
          eSkew[k]  = 1'b1;
        end
      end else begin
        mTimer[k] = 0;
      end
    end
    mPrevGen[k] = gen[k];
    mPrevN[k]   = nl[k];
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) modelReset();
    else begin
      cyc++;
      modelStep(0);
      modelStep(1);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chkOS(input string name, input logic [2047:0] act, input logic [2047:0] exp);
    int bad;
    bad = -1;
    nChecks++;
    for (int i = 15; i >= 0; i--) if (act[i*128 +: 128] !== exp[i*128 +: 128]) bad = i;
    if (bad < 0) nPass++;
    else $display("FAIL %s lane %0d: got %h, expected %h", name, bad,
                  act[bad*128 +: 128], exp[bad*128 +: 128]);
  endtask

  initial forever begin
    @(negedge clk);
    if (reset === 1'b1) begin
      chk("valid8", {127'b0, v8}, {127'b0, eValid[0]});
      chk("skew8", {127'b0, se8}, {127'b0, eSkew[0]});
      chkOS("os8", os8, eOS[0]);
      chk("valid32", {127'b0, v32}, {127'b0, eValid[1]});
      chk("skew32", {127'b0, se32}, {127'b0, eSkew[1]});
      chkOS("os32", os32, eOS[1]);
      if (v8)   begin validCount[0]++; lastValidCyc[0] = cyc; end
      if (v32)  begin validCount[1]++; lastValidCyc[1] = cyc; end
      if (se8)  begin skewCount[0]++;  lastSkewCyc[0]  = cyc; end
      if (se32) begin skewCount[1]++;  lastSkewCyc[1]  = cyc; end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [8:0] ts1(int lane, int s);
    if (s == 0) return {1'b1, 8'hBC};
    if (s < 3)  return {1'b1, 8'hF7};
    return {1'b0, 4'(lane), 4'(s)};
  endfunction

  function automatic logic [7:0] os3(int lane, int s);
    if (s == 0) return 8'h1E;
    return {4'(lane), 4'(s)};
  endfunction

  task automatic clr8();
    rxD8 = '0; rxK8 = '0; dv[0] = '0;
  endtask

  task automatic clr32();
    rxD32 = '0; rxK32 = '0; dv[1] = '0; sb[1] = '0;
  endtask

  task automatic put8(input int lane, input logic [8:0] ks);
    rxD8[lane*8 +: 8] = ks[7:0];
    rxK8[lane]        = ks[8];
    dv[0][lane]       = 1'b1;
  endtask

  task automatic put32(input int lane, input int b);
    for (int s = 0; s < 4; s++) rxD32[lane*32 + s*8 +: 8] = os3(lane, 4*b + s);
    dv[1][lane] = 1'b1;
    sb[1][lane] = (b == 0);
  endtask

  task automatic sendTs1(input logic [15:0] mask, output int tCom);
    tCom = cyc;
    for (int s = 0; s < 16; s++) begin
      clr8();
      for (int i = 0; i < 16; i++) if (mask[i]) put8(i, ts1(i, s));
      @(negedge clk);
    end
    clr8();
  endtask

  // ---------------- directed sequence ----------------
  int t, v0, s0;

  initial begin
    reset = 1'b0;
    gen[0] = 3'd1; gen[1] = 3'd3;
    nl[0] = 5'd4;  nl[1] = 5'd16;
    eidle[0] = 1'b0; eidle[1] = 1'b0;
    sb[0] = '0; sh[0] = '0; sh[1] = 32'h5555_5555;
    clr8(); clr32();
    #1;
    chk("reset valid8", {127'b0, v8}, 128'h0);
    chk("reset skew8", {127'b0, se8}, 128'h0);
    chk("reset os8", {127'b0, |os8}, 128'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Aligned TS1, 4 active lanes; inactive lanes also carry data but must read 0.
    v0 = validCount[0];
    sendTs1(16'hFFFF, t);
    repeat (4) @(negedge clk);
    chk("t1 strobes", 128'(validCount[0] - v0), 128'd1);
    chk("t1 latency", 128'(lastValidCyc[0] - t), 128'd17);
    chk("t1 lane0", os8[127:0], L0_TS1);
    chk("t1 lane1", os8[255:128], L1_TS1);
    chk("t1 inactive zero", {127'b0, |os8[2047:512]}, 128'h0);
    chk("t1 model lane1", eOS[0][255:128], L1_TS1);

    // Gen3, 32-bit, 16 lanes, lane 7 three beats late.
    v0 = validCount[1];
    t = cyc;
    for (int tt = 0; tt < 7; tt++) begin
      clr32();
      for (int i = 0; i < 16; i++) begin
        int b;
        b = tt - ((i == 7) ? 3 : 0);
        if (b >= 0 && b < 4) put32(i, b);
      end
      @(negedge clk);
    end
    clr32();
    repeat (4) @(negedge clk);
    chk("t2 strobes", 128'(validCount[1] - v0), 128'd1);
    chk("t2 latency", 128'(lastValidCyc[1] - t), 128'd8);
    chk("t2 lane0", os32[127:0], L0_OS3);
    chk("t2 lane7", os32[7*128 +: 128], L7_OS3);
    chk("t2 model lane7", eOS[1][7*128 +: 128], L7_OS3);
    chk("t2 no skew", 128'(skewCount[1]), 128'd0);

    // Skew timeout: 2 lanes, lane 1 silent; then an aligned pair succeeds.
    nl[0] = 5'd2;
    repeat (3) @(negedge clk);
    v0 = validCount[0]; s0 = skewCount[0];
    sendTs1(16'h0001, t);
    repeat (12) @(negedge clk);
    chk("t3 skew strobes", 128'(skewCount[0] - s0), 128'd1);
    chk("t3 skew time", 128'(lastSkewCyc[0] - t), 128'd24);
    chk("t3 no valid", 128'(validCount[0] - v0), 128'd0);
    sendTs1(16'h0003, t);
    repeat (4) @(negedge clk);
    chk("t3 recover strobes", 128'(validCount[0] - v0), 128'd1);
    chk("t3 recover latency", 128'(lastValidCyc[0] - t), 128'd17);
    chk("t3 lane1", os8[255:128], L1_TS1);
    chk("t3 upper zero", {127'b0, |os8[2047:256]}, 128'h0);

    // Restart: lane 0 sees a COM then 5 junk symbols before the real set.
    nl[0] = 5'd4;
    repeat (3) @(negedge clk);
    v0 = validCount[0];
    for (int s = 0; s < 6; s++) begin
      clr8();
      put8(0, (s == 0) ? {1'b1, 8'hBC} : {1'b0, 8'hAA});
      @(negedge clk);
    end
    sendTs1(16'h000F, t);
    repeat (4) @(negedge clk);
    chk("t4 strobes", 128'(validCount[0] - v0), 128'd1);
    chk("t4 latency", 128'(lastValidCyc[0] - t), 128'd17);
    chk("t4 lane0", os8[127:0], L0_TS1);

    // Electrical idle mid-collection.
    v0 = validCount[0];
    for (int s = 0; s < 8; s++) begin
      clr8();
      for (int i = 0; i < 4; i++) put8(i, ts1(i, s));
      @(negedge clk);
    end
    clr8();
    eidle[0] = 1'b1;
    repeat (3) @(negedge clk);
    eidle[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5 no strobe", 128'(validCount[0] - v0), 128'd0);
    chk("t5 os held", os8[127:0], L0_TS1);
    sendTs1(16'h000F, t);
    repeat (4) @(negedge clk);
    chk("t5 strobes", 128'(validCount[0] - v0), 128'd1);
    chk("t5 latency", 128'(lastValidCyc[0] - t), 128'd17);

    // rxDataValid[0] low for two beats (with a COM on the idle bus).
    v0 = validCount[0];
    t = cyc;
    for (int c = 0; c < 18; c++) begin
      clr8();
      for (int i = 1; i < 4; i++) if (c < 16) put8(i, ts1(i, c));
      if (c < 8) put8(0, ts1(0, c));
      else if (c < 10) begin rxD8[7:0] = 8'hBC; rxK8[0] = 1'b1; end
      else put8(0, ts1(0, c - 2));
      @(negedge clk);
    end
    clr8();
    repeat (4) @(negedge clk);
    chk("t6 strobes", 128'(validCount[0] - v0), 128'd1);
    chk("t6 latency", 128'(lastValidCyc[0] - t), 128'd19);
    chk("t6 lane0", os8[127:0], L0_TS1);

    // Asynchronous reset mid-set.
    for (int s = 0; s < 8; s++) begin
      clr8();
      for (int i = 0; i < 4; i++) put8(i, ts1(i, s));
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    chk("rst os8 zero", {127'b0, |os8}, 128'h0);
    chk("rst os32 zero", {127'b0, |os32}, 128'h0);
    chk("rst valid8", {127'b0, v8}, 128'h0);
    chk("rst skew8", {127'b0, se8}, 128'h0);
    @(negedge clk);
    clr8();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    v0 = validCount[0];
    sendTs1(16'h000F, t);
    repeat (4) @(negedge clk);
    chk("post-rst strobes", 128'(validCount[0] - v0), 128'd1);
    chk("post-rst latency", 128'(lastValidCyc[0] - t), 128'd17);
    chk("post-rst lane1", os8[255:128], L1_TS1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
